// File: rtl/aes_pkg.sv
// Purpose: shared AES constants, cipher FSM encoding and GF(2^8) byte helpers.
// Latency: none; every function is pure combinational logic.
// Backpressure: not applicable (no handshake in this package).
//
// Contents: BLOCK_W/ROUND_W widths, cipher_state_e, sbox(), xtime(), gf_mul3().
package aes_pkg;

    localparam int BLOCK_W = 128;
    localparam int ROUND_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUNDS = 2'd1,
        FINAL  = 2'd2,
        DONE   = 2'd3
    } cipher_state_e;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry b sits at bit offset (255-b)*8; ~b is exactly 255-b for a byte.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    // Multiply by x (0x02) modulo the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by 0x03 = x + 1.
    function automatic logic [7:0] gf_mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

endpackage

// File: rtl/cipher_round.sv
// Purpose: one AES cipher round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
//
// Ports:
//   state_i     [127:0]  round input, byte 0 in bits [127:120] (column-major)
//   round_key_i [127:0]  key XORed in last
//   skip_mix_i           1 bypasses MixColumns (last round of the cipher)
//   state_o     [127:0]  round output
module cipher_round
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] state_i,
    input  logic [BLOCK_W-1:0] round_key_i,
    input  logic               skip_mix_i,
    output logic [BLOCK_W-1:0] state_o
);

    // Byte n of the block is state element row n%4, column n/4.
    logic [7:0] sub_b [16];
    logic [7:0] shf_b [16];
    logic [7:0] mix_b [16];

    for (genvar n = 0; n < 16; n++) begin : g_sub
        assign sub_b[n] = sbox(state_i[127-8*n -: 8]);
    end

    // Row r rotates left by r columns: new[r][c] = old[r][(c+r)%4].
    for (genvar c = 0; c < 4; c++) begin : g_shift_col
        for (genvar r = 0; r < 4; r++) begin : g_shift_row
            assign shf_b[r+4*c] = sub_b[r+4*((c+r)%4)];
        end
    end

    for (genvar c = 0; c < 4; c++) begin : g_mix
        assign mix_b[4*c+0] = xtime(shf_b[4*c+0]) ^ gf_mul3(shf_b[4*c+1])
                            ^ shf_b[4*c+2]        ^ shf_b[4*c+3];
        assign mix_b[4*c+1] = shf_b[4*c+0]        ^ xtime(shf_b[4*c+1])
                            ^ gf_mul3(shf_b[4*c+2]) ^ shf_b[4*c+3];
        assign mix_b[4*c+2] = shf_b[4*c+0]        ^ shf_b[4*c+1]
                            ^ xtime(shf_b[4*c+2]) ^ gf_mul3(shf_b[4*c+3]);
        assign mix_b[4*c+3] = gf_mul3(shf_b[4*c+0]) ^ shf_b[4*c+1]
                            ^ shf_b[4*c+2]        ^ xtime(shf_b[4*c+3]);
    end

    for (genvar n = 0; n < 16; n++) begin : g_ark
        assign state_o[127-8*n -: 8] = (skip_mix_i ? shf_b[n] : mix_b[n])
                                     ^ round_key_i[127-8*n -: 8];
    end

endmodule

// File: rtl/cipher_iter.sv
// Purpose: iterative AES forward cipher (128/192/256-bit keys), one round per clock.
// Latency: out_valid is seen high at the (Nr+1)th rising edge after the accepting edge.
// Backpressure: result held in DONE until out_ready; in_ready is low until then.
//
// Ports:
//   clk, reset_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready     plaintext handshake; in_ready high only while idle
//   plainText  [127:0]      input block, byte 0 in bits [127:120]
//   keys [128*(Nr+1)-1:0]   expanded schedule, round key i at keys[128*i +: 128];
//                           must stay stable from acceptance until out_valid
//   out_valid / out_ready   result handshake; out_valid high only in DONE
//   cipherText [127:0]      encrypted block, stable while out_valid is high
module cipher_iter
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = Nk + 6
)
(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BLOCK_W-1:0]       plainText,
    input  logic [128*(Nr+1)-1:0]    keys,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BLOCK_W-1:0]       cipherText
);

    // Round index of the last round that still applies MixColumns.
    localparam logic [ROUND_W-1:0] LAST_MID = ROUND_W'(Nr - 1);

    cipher_state_e      fsm_q, fsm_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [BLOCK_W-1:0] blk_q, blk_d;
    logic [BLOCK_W-1:0] ct_q, ct_d;

    logic [BLOCK_W-1:0] round_key;
    logic [BLOCK_W-1:0] round_out;
    logic               skip_mix;

    // The schedule is never registered; the round counter picks the live key.
    // round_q never exceeds Nr, so the select stays inside the keys bus.
    assign round_key = keys[{round_q, 7'd0} +: BLOCK_W];

    cipher_round u_round (
        .state_i     (blk_q),
        .round_key_i (round_key),
        .skip_mix_i  (skip_mix),
        .state_o     (round_out)
    );

    always_comb begin
        fsm_d     = fsm_q;
        round_d   = round_q;
        blk_d     = blk_q;
        ct_d      = ct_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        skip_mix  = 1'b0;

        case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // Initial AddRoundKey with round key 0.
                    blk_d   = plainText ^ keys[BLOCK_W-1:0];
                    round_d = ROUND_W'(1);
                    fsm_d   = ROUNDS;
                end
            end
            ROUNDS: begin
                blk_d   = round_out;
                round_d = round_q + ROUND_W'(1);
                if (round_q == LAST_MID) begin
                    fsm_d = FINAL;
                end
            end
            FINAL: begin
                // round_q == Nr here; last round drops MixColumns.
                skip_mix = 1'b1;
                blk_d    = round_out;
                ct_d     = round_out;
                fsm_d    = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    round_d = '0;
                    fsm_d   = IDLE;
                end
            end
            default: begin
                round_d = '0;
                fsm_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q   <= IDLE;
            round_q <= '0;
            blk_q   <= '0;
            ct_q    <= '0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            blk_q   <= blk_d;
            ct_q    <= ct_d;
        end
    end

    assign cipherText = ct_q;

endmodule

// File: tb/tb_cipher_iter.sv
// Purpose: directed self-checking bench for cipher_iter at all three key sizes.
// Latency: checks the Nr+1 edge result latency for every block.
// Backpressure: holds out_ready low and checks result/ready behaviour.
module tb_cipher_iter;

    localparam logic [127:0] PT_A   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         iv   [3];
    logic         ordy [3];
    logic         irdy [3];
    logic         ovld [3];
    logic [127:0] pt   [3];
    logic [127:0] ct   [3];
    logic [128*11-1:0] keys4;
    logic [128*13-1:0] keys6;
    logic [128*15-1:0] keys8;
    logic [1919:0] ks128, ks192, ks256, ksb;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cipher_iter #(.Nk(4)) u_aes128 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv[0]), .in_ready(irdy[0]),
        .plainText(pt[0]), .keys(keys4), .out_valid(ovld[0]), .out_ready(ordy[0]),
        .cipherText(ct[0]));
    cipher_iter #(.Nk(6)) u_aes192 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv[1]), .in_ready(irdy[1]),
        .plainText(pt[1]), .keys(keys6), .out_valid(ovld[1]), .out_ready(ordy[1]),
        .cipherText(ct[1]));
    cipher_iter #(.Nk(8)) u_aes256 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv[2]), .in_ready(irdy[2]),
        .plainText(pt[2]), .keys(keys8), .out_valid(ovld[2]), .out_ready(ordy[2]),
        .cipherText(ct[2]));

    // ---------------- reference key schedule ----------------
    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box built from its definition: GF inverse (a^254) then affine map.
    function automatic logic [7:0] tb_sbox(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h00;
        if (a != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = tb_mul(inv, a);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {tb_sbox(w[31:24]), tb_sbox(w[23:16]), tb_sbox(w[15:8]), tb_sbox(w[7:0])};
    endfunction

    // Key is left-aligned in 256 bits; round key r lands at ks[128*r +: 128].
    function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [1919:0] ks;
        int nr;
        nr   = nk + 6;
        rcon = 8'h01;
        ks   = '0;
        for (int i = 0; i < 4*(nr+1); i++) begin
            if (i < nk) begin
                w[i] = key[255-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                    rcon = tb_mul(rcon, 8'h02);
                end else if (nk > 6 && i % nk == 4) begin
                    t = sub_word(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int r = 0; r <= nr; r++) ks[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return ks;
    endfunction

    // ---------------- checking and handshake helpers ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns #1 after the accepting edge.
    task automatic accept(input int u, input logic [127:0] blk, input string tag);
        pt[u] = blk;
        iv[u] = 1'b1;
        check({tag, "_in_ready"}, 128'(irdy[u]), 128'd1);
        @(posedge clk);
        #1;
        iv[u] = 1'b0;
    endtask

    // Counts edges after acceptance; ends at the negedge where out_valid is first seen.
    task automatic wait_valid(input int u, input int exp_lat, input logic [127:0] exp_ct,
                              input string tag);
        int lat = 0;
        bit got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            got = ovld[u];
        end
        check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
        check({tag, "_ct"}, ct[u], exp_ct);
    endtask

    task automatic handshake(input int u, input string tag);
        ordy[u] = 1'b1;
        @(posedge clk);
        #1;
        ordy[u] = 1'b0;
        @(negedge clk);
        check({tag, "_idle_ready"}, 128'(irdy[u]), 128'd1);
        check({tag, "_valid_clear"}, 128'(ovld[u]), 128'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int stray;
        reset_n = 1'b0;
        for (int u = 0; u < 3; u++) begin
            iv[u]   = 1'b0;
            ordy[u] = 1'b0;
            pt[u]   = '0;
        end
        ks128 = expand(KEY128, 4);
        ks192 = expand(KEY192, 6);
        ks256 = expand(KEY256, 8);
        ksb   = expand(KEY_B, 4);
        keys4 = ks128[128*11-1:0];
        keys6 = ks192[128*13-1:0];
        keys8 = ks256[128*15-1:0];

        #2;
        for (int u = 0; u < 3; u++) begin
            check($sformatf("reset%0d_in_ready", u), 128'(irdy[u]), 128'd1);
            check($sformatf("reset%0d_out_valid", u), 128'(ovld[u]), 128'd0);
            check($sformatf("reset%0d_ct", u), ct[u], 128'd0);
        end

        // Acceptance on the very first edge after release.
        @(negedge clk);
        reset_n = 1'b1;
        accept(0, PT_A, "aes128");
        wait_valid(0, 11, CT128, "aes128");
        handshake(0, "aes128");

        accept(1, PT_A, "aes192");
        wait_valid(1, 13, CT192, "aes192");
        handshake(1, "aes192");

        accept(2, PT_A, "aes256");
        wait_valid(2, 15, CT256, "aes256");
        handshake(2, "aes256");

        // Backpressure: result held for 20 cycles, offered block ignored.
        accept(0, PT_A, "bp");
        wait_valid(0, 11, CT128, "bp");
        pt[0] = PT_B;
        iv[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d_valid", i), 128'(ovld[0]), 128'd1);
            check($sformatf("bp_hold%0d_ct", i), ct[0], CT128);
            check($sformatf("bp_hold%0d_in_ready", i), 128'(irdy[0]), 128'd0);
        end
        iv[0] = 1'b0;
        handshake(0, "bp");

        // Reset while round 5 is the current round.
        accept(0, PT_A, "rst5");
        repeat (4) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst5_out_valid", 128'(ovld[0]), 128'd0);
        check("rst5_ct", ct[0], 128'd0);
        check("rst5_in_ready", 128'(irdy[0]), 128'd1);
        @(negedge clk);
        reset_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ovld[0]) stray++;
        end
        check("rst5_abandoned", 128'(stray), 128'd0);
        keys4 = ksb[128*11-1:0];
        accept(0, PT_B, "post_rst");
        wait_valid(0, 11, CT_B, "post_rst");
        handshake(0, "post_rst");

        // Back-to-back with out_ready tied high; second block waits in in_valid.
        keys4   = ks128[128*11-1:0];
        ordy[0] = 1'b1;
        pt[0]   = PT_A;
        iv[0]   = 1'b1;
        check("b2b_first_in_ready", 128'(irdy[0]), 128'd1);
        @(posedge clk);
        #1;
        pt[0] = PT_B;
        wait_valid(0, 11, CT128, "b2b_first");
        keys4 = ksb[128*11-1:0];
        @(negedge clk);
        check("b2b_second_in_ready", 128'(irdy[0]), 128'd1);
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        wait_valid(0, 11, CT_B, "b2b_second");
        @(negedge clk);
        check("b2b_end_in_ready", 128'(irdy[0]), 128'd1);
        ordy[0] = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cipher_iter.md
CIPHER_ITER -- requirements
Module: cipher_iter

Interface
REQ-001 SHALL have parameter Nk, default 4, key length in 32-bit words; legal values 4, 6, 8.
REQ-002 SHALL have parameter Nr, default Nk+6, round count (10/12/14).
REQ-003 SHALL have port clk  input  1  single clock, all flops rising-edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  plaintext block offered.
REQ-006 SHALL have port in_ready  output  1  block can be accepted.
REQ-007 SHALL have port plainText  input  128  plaintext block, byte 0 in bits [127:120].
REQ-008 SHALL have port keys  input  128*(Nr+1)  expanded schedule, [0:...] order; round key i = keys[128*i +: 128].
REQ-009 SHALL have port out_valid  output  1  cipherText holds a finished block.
REQ-010 SHALL have port out_ready  input  1  consumer takes the block.
REQ-011 SHALL have port cipherText  output  128  encrypted block.

Function
REQ-012 SHALL implement FIPS-197 forward Cipher, iteratively, one round per cycle.
REQ-013 SHALL use FSM states IDLE, ROUNDS, FINAL, DONE.
REQ-014 IDLE: in_ready=1; on in_valid, state reg <= plainText ^ key0, round <= 1, go to ROUNDS.
REQ-015 ROUNDS: state <= SubBytes/ShiftRows/MixColumns/AddRoundKey(key[round]), round++; after round Nr-1, go to FINAL.
REQ-016 FINAL: state <= SubBytes/ShiftRows/AddRoundKey(key[Nr]), no MixColumns; cipherText <= result; go to DONE.
REQ-017 DONE: out_valid=1, cipherText stable; on out_ready go to IDLE.
REQ-018 Latency: first rising edge with out_valid=1 SHALL be exactly Nr+1 edges after the accepting edge (11/13/15).
REQ-019 in_ready SHALL be 1 only in IDLE; in_valid outside IDLE SHALL be ignored.
REQ-020 out_valid SHALL be 1 only in DONE; block held indefinitely while out_ready=0.
REQ-021 out_ready outside DONE SHALL be ignored.
REQ-022 keys SHALL be held stable by the producer from acceptance until out_valid; not captured internally.
REQ-023 Round counter SHALL be 4 bits, 0..Nr, never wrap; reset to 0 on return to IDLE.
REQ-024 Throughput: next block accepted no earlier than the edge after the out_ready handshake.

Reset
REQ-025 reset_n low SHALL immediately force IDLE, round=0, in_ready=1, out_valid=0, cipherText=0, state reg=0.
REQ-026 Reset mid-operation SHALL abandon the block; no out_valid for it after release.
REQ-027 First acceptance SHALL be possible on the first rising edge after reset_n deasserts.

Structure
REQ-028 Package aes_pkg SHALL hold the S-box function, xtime/GF multiply, the FSM state encoding and block width constant 128.
REQ-029 One sub-module cipher_round SHALL do SubBytes, ShiftRows, MixColumns (with bypass input for the final round) and AddRoundKey, purely combinational.

Verification
REQ-030 AES-128 (Nk=4): pt 00112233445566778899aabbccddeeff, key 000102..0f -> 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid 11 edges after accept.
REQ-031 AES-192 (Nk=6): same pt, key 000102..17 -> dda97ca4864cdfe06eaf70a0ec0d7191, latency 13.
REQ-032 AES-256 (Nk=8): same pt, key 000102..1f -> 8ea2b7ca516745bfeafc49904b496089, latency 15.
REQ-033 Backpressure: hold out_ready=0 for 20 cycles -> out_valid and cipherText stable, in_ready=0, second in_valid ignored.
REQ-034 Reset at round 5 -> outputs zero, in_ready=1 next edge; new FIPS-197 block afterwards encrypts correctly.
REQ-035 Back-to-back: two blocks, out_ready tied 1 -> both correct, second accepted on the edge after first handshake.
